// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: synchronises NUM_IRQ lines, latches them as
// level or rising-edge events, and raises a registered request to the CPU.
module wb_irq_ctrl #(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  input  logic [31:0]        wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  output logic               wb_ack_o,
  output logic               wb_stall_o,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  localparam logic [5:0] OFF_PEND = 6'h00;
  localparam logic [5:0] OFF_EN   = 6'h01;
  localparam logic [5:0] OFF_EDGE = 6'h02;
  localparam logic [5:0] OFF_ACT  = 6'h03;
  localparam logic [5:0] OFF_VEC  = 6'h04;
  localparam logic [5:0] OFF_SET  = 6'h05;

  function automatic logic [31:0] ext(input logic [NUM_IRQ-1:0] v);
    ext = '0;
    ext[NUM_IRQ-1:0] = v;
  endfunction

  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic               irq_q, irq_d;

  logic               acc, wr;
  logic [5:0]         off;
  logic [31:0]        bmask, wm32;
  logic [NUM_IRQ-1:0] wmask, wdat, clr, set, rise, active, edge_chg, pend_rule;
  logic [4:0]         vec_idx;
  logic [31:0]        rdata;
  logic               unused_ok;

  assign unused_ok = &{1'b0, wb_adr_i[31:8], wb_adr_i[1:0], wm32};

  always_comb begin
    acc    = wb_cyc_i & wb_stb_i;
    wr     = acc & wb_we_i;
    off    = wb_adr_i[7:2];
    bmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wm32   = wb_dat_i & bmask;
    wmask  = bmask[NUM_IRQ-1:0];
    wdat   = wm32[NUM_IRQ-1:0];
    active = pend_q & en_q;
    rise   = s2_q & ~s3_q;

    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 5'(i);
    end

    unique case (off)
      OFF_PEND: rdata = ext(pend_q);
      OFF_EN:   rdata = ext(en_q);
      OFF_EDGE: rdata = ext(edge_q);
      OFF_ACT:  rdata = ext(active);
      OFF_VEC:  rdata = {|active, 26'd0, vec_idx};
      default:  rdata = '0;
    endcase

    en_d   = (wr && off == OFF_EN)   ? ((en_q & ~wmask) | wdat)   : en_q;
    edge_d = (wr && off == OFF_EDGE) ? ((edge_q & ~wmask) | wdat) : edge_q;
    clr    = (wr && off == OFF_PEND) ? wdat : '0;
    set    = (wr && off == OFF_SET)  ? wdat : '0;

    // Set beats clear on edge sources; level sources just track the line.
    pend_rule = (edge_q & ((pend_q & ~clr) | rise | set)) | (~edge_q & s2_q);
    // A bit whose source type is being switched holds for this one cycle.
    edge_chg  = edge_d ^ edge_q;
    pend_d    = (pend_rule & ~edge_chg) | (pend_q & edge_chg);

    irq_d = |active;
    ack_d = acc;
    dat_d = acc ? rdata : dat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      pend_q <= '0;
      en_q   <= '0;
      edge_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      s1_q   <= irq_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      en_q   <= en_d;
      edge_q <= edge_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign irq_out    = irq_q;

endmodule
